fetch_pc_ctrl: RTL and testbench
================================

FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h4000_0000, first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  hold fetch; PC and state frozen except pending-redirect capture.
REQ-005 br_taken_ex  input  1  EX-stage branch/JALR resolved taken (PCSel==2'b10 from branch resolution).
REQ-006 br_target_ex  input  32  EX redirect target.
REQ-007 jal_id  input  1  JAL decoded in ID.
REQ-008 jal_target_id  input  32  JAL target.
REQ-009 pc_if  output  32  current fetch PC (registered).
REQ-010 fetch_valid  output  1  instruction fetched at pc_if is on the correct path.
REQ-011 pc_sel  output  2  source of the next PC: 00 pc+4, 01 JAL, 10 EX branch/JALR, 11 pending/reset vector.
REQ-012 kill_if  output  1  squash IF/ID register contents this cycle.
REQ-013 kill_id  output  1  squash ID/EX register contents this cycle.
REQ-014 redirect_count  output  32  count of applied redirects.

Function
REQ-015 FSM states BOOT, RUN, STALL, BUBBLE; state register 2 bits.
REQ-016 BOOT: pc_if=RESET_PC, fetch_valid=0, pc_sel=11; next state RUN unconditionally, pc_if stays RESET_PC.
REQ-017 RUN, stall=0, no redirect: pc_if <= pc_if+4 (modulo 2^32, wrap 32'hFFFF_FFFC -> 0), pc_sel=00, fetch_valid=1.
REQ-018 Redirect priority: rst > br_taken_ex > pending > jal_id > sequential.
REQ-019 br_taken_ex=1 with stall=0: pc_if <= br_target_ex, pc_sel=10, kill_if=1, kill_id=1, next state BUBBLE.
REQ-020 jal_id=1, br_taken_ex=0, stall=0: pc_if <= jal_target_id, pc_sel=01, kill_if=1, kill_id=0, next state BUBBLE.
REQ-021 br_taken_ex and jal_id in the same cycle: JAL ignored, not recorded as pending.
REQ-022 BUBBLE: fetch_valid=0 for exactly one cycle; advances pc+4 and returns to RUN; a redirect in BUBBLE is handled as in RUN.
REQ-023 stall=1 in RUN or BUBBLE: pc_if held, next state STALL, kill_* = 0.
REQ-024 Redirect (EX or JAL) arriving while stall=1: captured into pend_valid/pend_target/pend_src; later EX redirect overwrites pending JAL; a pending EX redirect is never overwritten by JAL.
REQ-025 STALL, stall drops: if pend_valid, pc_if <= pend_target, pc_sel=11, kill_if=1, kill_id=1 for EX source else 0, pend_valid cleared, next BUBBLE; else resume RUN with PC unchanged.
REQ-026 Redirect arriving the same cycle stall drops overrides any pending entry.
REQ-027 kill_if, kill_id, pc_sel are combinational from state and inputs; all other outputs registered.
REQ-028 redirect_count increments by 1 per applied redirect (not per capture); wraps at 2^32.
REQ-029 Redirect target not 4-byte aligned: bits [1:0] forced to 0.

Reset
REQ-030 rst=1 at any edge, including mid-stall or mid-redirect: state=BOOT, pc_if=RESET_PC, pend_valid=0, redirect_count=0.
REQ-031 During rst: fetch_valid=0, kill_if=1, kill_id=1, pc_sel=11.
REQ-032 Inputs ignored the cycle rst is high; no pending capture.

Structure
REQ-033 Shared package holds FSM state encoding, pc_sel encodings (PCSEL_SEQ/JAL/BR/PEND) and RESET_PC default.
REQ-034 One sub-module pend_redirect_reg (pending valid/target/source holding register); next-PC mux and FSM in the top.

Verification
REQ-035 Reset release: cycle 0 pc_if=0x40000000 fetch_valid=0; cycle 1 0x40000000 valid; cycle 2 0x40000004.
REQ-036 br_taken_ex=1, target 0x40000100 in RUN -> next pc_if=0x40000100, kill_if=kill_id=1 that cycle, one fetch_valid=0 cycle, redirect_count+1.
REQ-037 br_taken_ex and jal_id same cycle (targets 0x200/0x300) -> pc_if=0x200, pc_sel=10, count+1 only.
REQ-038 stall 3 cycles with jal_id then br_taken_ex (0x500) captured -> pc_if held; on release pc_if=0x500, kill_id=1, count+1.
REQ-039 rst asserted during STALL with pend_valid=1 -> pc_if=RESET_PC, pend cleared, no redirect after release.
REQ-040 pc_if=0xFFFFFFFC sequential -> 0x00000000; misaligned target 0x1002 -> pc_if=0x1000.

Source files
------------

// File: rtl/fetch_pc_ctrl_pkg.sv
// fetch_pc_ctrl_pkg: shared encodings for the fetch PC controller
package fetch_pc_ctrl_pkg;
   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_STALL, ST_BUBBLE} state_t;
   typedef enum logic {SRC_JAL, SRC_EX} pend_src_t;
   localparam logic [1:0] PCSEL_SEQ  = 2'b00;
   localparam logic [1:0] PCSEL_JAL  = 2'b01;
   localparam logic [1:0] PCSEL_BR   = 2'b10;
   localparam logic [1:0] PCSEL_PEND = 2'b11;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;
   function automatic logic [31:0] align4(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/pend_redirect_reg.sv
// pend_redirect_reg: holds a redirect that arrived while fetch was stalled
import fetch_pc_ctrl_pkg::*;
module pend_redirect_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clr,
   input  logic        i_cap_ex,
   input  logic        i_cap_jal,
   input  logic [31:0] i_ex_target,
   input  logic [31:0] i_jal_target,
   output logic        o_valid,
   output logic [31:0] o_target,
   output pend_src_t   o_src
);
   logic        r_valid;
   logic [31:0] r_target;
   pend_src_t   r_src;
   // an older EX redirect always wins over a younger JAL
   always_ff @(posedge clk)
      if (rst || i_clr) begin
         r_valid <= 1'b0;
      end else if (i_cap_ex) begin
         r_valid  <= 1'b1;
         r_target <= align4(i_ex_target);
         r_src    <= SRC_EX;
      end else if (i_cap_jal && !(r_valid && r_src == SRC_EX)) begin
         r_valid  <= 1'b1;
         r_target <= align4(i_jal_target);
         r_src    <= SRC_JAL;
      end
   assign o_valid  = r_valid;
   assign o_target = r_target;
   assign o_src    = r_src;
endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch PC sequencing with EX/JAL redirects, stall and pending redirect
import fetch_pc_ctrl_pkg::*;
module fetch_pc_ctrl #(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        br_taken_ex,
   input  logic [31:0] br_target_ex,
   input  logic        jal_id,
   input  logic [31:0] jal_target_id,
   output logic [31:0] pc_if,
   output logic        fetch_valid,
   output logic [1:0]  pc_sel,
   output logic        kill_if,
   output logic        kill_id,
   output logic [31:0] redirect_count
);
   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt, r_count, w_pend_target;
   logic        r_fv, w_live, w_go, w_apply_br, w_apply_pend, w_apply_jal, w_redirect, w_pend_valid;
   pend_src_t   w_pend_src;
   assign w_live       = r_state != ST_BOOT;
   assign w_go         = w_live && !stall;
   assign w_apply_br   = w_go && br_taken_ex;
   assign w_apply_pend = w_go && !br_taken_ex && w_pend_valid && r_state == ST_STALL;
   assign w_apply_jal  = w_go && !br_taken_ex && !w_apply_pend && jal_id;
   assign w_redirect   = w_apply_br || w_apply_pend || w_apply_jal;
   pend_redirect_reg u_pend (
      .clk          (clk),
      .rst          (rst),
      .i_clr        (!stall),
      .i_cap_ex     (w_live && stall && br_taken_ex),
      .i_cap_jal    (w_live && stall && jal_id && !br_taken_ex),
      .i_ex_target  (br_target_ex),
      .i_jal_target (jal_target_id),
      .o_valid      (w_pend_valid),
      .o_target     (w_pend_target),
      .o_src        (w_pend_src)
   );
   always_comb begin
      pc_sel  = (rst || !w_live) ? PCSEL_PEND : w_apply_br ? PCSEL_BR :
                w_apply_pend ? PCSEL_PEND : w_apply_jal ? PCSEL_JAL : PCSEL_SEQ;
      kill_if = rst || w_redirect;
      kill_id = rst || w_apply_br || (w_apply_pend && w_pend_src == SRC_EX);
      w_pc_nxt = !w_live ? RESET_PC : stall ? r_pc : w_apply_br ? align4(br_target_ex) :
                 w_apply_pend ? w_pend_target : w_apply_jal ? align4(jal_target_id) :
                 r_state == ST_STALL ? r_pc : r_pc + 32'd4;
      w_state_nxt = !w_live ? ST_RUN : stall ? ST_STALL : w_redirect ? ST_BUBBLE : ST_RUN;
   end
   // fetch_valid is frozen with the PC while stalled
   always_ff @(posedge clk)
      if (rst) begin
         r_state <= ST_BOOT;
         r_pc    <= RESET_PC;
         r_fv    <= 1'b0;
         r_count <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_fv    <= (w_state_nxt == ST_STALL) ? r_fv : (w_state_nxt == ST_RUN);
         r_count <= r_count + 32'(w_redirect);
      end
   assign pc_if          = r_pc;
   assign fetch_valid    = r_fv;
   assign redirect_count = r_count;
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed vectors with a scoreboard queue checked by a mid-cycle monitor
module tb_fetch_pc_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1, stall = 1'b0, br_taken_ex = 1'b0, jal_id = 1'b0;
   logic [31:0] br_target_ex = '0, jal_target_id = '0;
   logic [31:0] pc_if, redirect_count;
   logic        fetch_valid, kill_if, kill_id;
   logic [1:0]  pc_sel;
   typedef struct packed {
      logic [31:0] pc;
      logic        fv;
      logic [31:0] cnt;
      logic [1:0]  sel;
      logic        kif;
      logic        kid;
   } obs_t;
   obs_t q[$];
   obs_t e, a;
   int n_vec = 0, n_err = 0;
   always #5 clk = ~clk;
   fetch_pc_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .br_taken_ex    (br_taken_ex),
      .br_target_ex   (br_target_ex),
      .jal_id         (jal_id),
      .jal_target_id  (jal_target_id),
      .pc_if          (pc_if),
      .fetch_valid    (fetch_valid),
      .pc_sel         (pc_sel),
      .kill_if        (kill_if),
      .kill_id        (kill_id),
      .redirect_count (redirect_count)
   );
   // one vector per cycle: inputs for the cycle and the outputs expected during it
   task automatic step(input logic r, s, b, input logic [31:0] bt, input logic j,
                       input logic [31:0] jt, input logic [31:0] pc, input logic fv,
                       input logic [31:0] cnt, input logic [1:0] sel, input logic kif, kid);
      @(posedge clk);
      #1;
      rst = r; stall = s; br_taken_ex = b; br_target_ex = bt; jal_id = j; jal_target_id = jt;
      q.push_back('{pc, fv, cnt, sel, kif, kid});
   endtask
   always @(negedge clk)
      if (q.size() > 0) begin
         e = q.pop_front();
         a = '{pc_if, fetch_valid, redirect_count, pc_sel, kill_if, kill_id};
         n_vec++;
         if (a !== e) begin
            n_err++;
            $display("FAIL vec%0d: got pc=%h fv=%b cnt=%0d sel=%b kif=%b kid=%b, want pc=%h fv=%b cnt=%0d sel=%b kif=%b kid=%b",
                     n_vec, a.pc, a.fv, a.cnt, a.sel, a.kif, a.kid, e.pc, e.fv, e.cnt, e.sel, e.kif, e.kid);
         end
      end
   initial begin
      step(1, 0, 1, 32'h123, 0, 0, 32'h4000_0000, 0, 0, 2'b11, 1, 1);
      step(0, 0, 0, 0, 0, 0, 32'h4000_0000, 0, 0, 2'b11, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h4000_0000, 1, 0, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h4000_0004, 1, 0, 2'b00, 0, 0);
      step(0, 0, 1, 32'h4000_0100, 0, 0, 32'h4000_0008, 1, 0, 2'b10, 1, 1);
      step(0, 0, 0, 0, 0, 0, 32'h4000_0100, 0, 1, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h4000_0104, 1, 1, 2'b00, 0, 0);
      step(0, 0, 1, 32'h200, 1, 32'h300, 32'h4000_0108, 1, 1, 2'b10, 1, 1);
      step(0, 0, 0, 0, 0, 0, 32'h200, 0, 2, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h204, 1, 2, 2'b00, 0, 0);
      step(0, 0, 0, 0, 1, 32'h1002, 32'h208, 1, 2, 2'b01, 1, 0);
      step(0, 0, 0, 0, 0, 0, 32'h1000, 0, 3, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h1004, 1, 3, 2'b00, 0, 0);
      step(0, 1, 0, 0, 1, 32'h600, 32'h1008, 1, 3, 2'b00, 0, 0);
      step(0, 1, 1, 32'h500, 0, 0, 32'h1008, 1, 3, 2'b00, 0, 0);
      step(0, 1, 0, 0, 1, 32'h700, 32'h1008, 1, 3, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h1008, 1, 3, 2'b11, 1, 1);
      step(0, 0, 0, 0, 0, 0, 32'h500, 0, 4, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h504, 1, 4, 2'b00, 0, 0);
      step(0, 1, 0, 0, 1, 32'h800, 32'h508, 1, 4, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h508, 1, 4, 2'b11, 1, 0);
      step(0, 0, 0, 0, 0, 0, 32'h800, 0, 5, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h804, 1, 5, 2'b00, 0, 0);
      step(0, 1, 0, 0, 1, 32'h900, 32'h808, 1, 5, 2'b00, 0, 0);
      step(0, 0, 1, 32'hA00, 0, 0, 32'h808, 1, 5, 2'b10, 1, 1);
      step(0, 0, 0, 0, 0, 0, 32'hA00, 0, 6, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'hA04, 1, 6, 2'b00, 0, 0);
      step(0, 1, 0, 0, 0, 0, 32'hA08, 1, 6, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'hA08, 1, 6, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'hA08, 1, 6, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'hA0C, 1, 6, 2'b00, 0, 0);
      step(0, 1, 1, 32'hB00, 0, 0, 32'hA10, 1, 6, 2'b00, 0, 0);
      step(1, 1, 0, 0, 0, 0, 32'hA10, 1, 6, 2'b11, 1, 1);
      step(0, 0, 0, 0, 0, 0, 32'h4000_0000, 0, 0, 2'b11, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h4000_0000, 1, 0, 2'b00, 0, 0);
      step(0, 1, 0, 0, 0, 0, 32'h4000_0004, 1, 0, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h4000_0004, 1, 0, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h4000_0004, 1, 0, 2'b00, 0, 0);
      step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h4000_0008, 1, 0, 2'b10, 1, 1);
      step(0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 1, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h0, 1, 1, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h4, 1, 1, 2'b00, 0, 0);
      step(0, 0, 0, 0, 1, 32'h2000, 32'h8, 1, 1, 2'b01, 1, 0);
      step(0, 0, 1, 32'h3003, 0, 0, 32'h2000, 0, 2, 2'b10, 1, 1);
      step(0, 0, 0, 0, 0, 0, 32'h3000, 0, 3, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h3004, 1, 3, 2'b00, 0, 0);
      step(0, 0, 0, 0, 1, 32'h4000, 32'h3008, 1, 3, 2'b01, 1, 0);
      step(0, 1, 0, 0, 0, 0, 32'h4000, 0, 4, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h4000, 0, 4, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h4000, 1, 4, 2'b00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h4004, 1, 4, 2'b00, 0, 0);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         n_err++;
         $display("FAIL drain: got %0d vectors unchecked, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
